// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned radix-2 restoring divider (2N/N), one quotient bit per clock
// Optional build macro DIV_SELF_CHECK_EN adds a Q*V+R==D and R<V result check driving chk_err.
module seq_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           dbz,
    output logic           chk_err
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2*N-1:0] shift;
    logic [N-1:0]   pr;
    logic [N-1:0]   divisor_q;
    logic [CW-1:0]  count;

    logic [N:0]     pr_shift;
    logic [N-1:0]   pr_sub;
    logic           ge;
    logic [N-1:0]   pr_next;
    logic [2*N-1:0] shift_next;
    logic           last_iter;

    // After a restore step PR < V, so it always fits in N bits; only the
    // shifted value PR' needs the extra bit. Modular N-bit subtraction yields
    // the exact difference whenever PR' >= V.
    always_comb begin
        pr_shift   = {pr, shift[2*N-1]};
        ge         = pr_shift >= {1'b0, divisor_q};
        pr_sub     = pr_shift[N-1:0] - divisor_q;
        pr_next    = ge ? pr_sub : pr_shift[N-1:0];
        shift_next = {shift[2*N-2:0], ge};
        last_iter  = (state == BUSY) && (count == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (count == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift     <= '0;
            pr        <= '0;
            divisor_q <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor_q <= divisor;
                        shift     <= dividend;
                        pr        <= '0;
                        count     <= '0;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend[N-1:0];
                            dbz       <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    shift <= shift_next;
                    pr    <= pr_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient  <= shift_next;
                        remainder <= pr_next;
                        dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_SELF_CHECK_EN
    logic [2*N-1:0] dividend_q;
    logic [3*N-1:0] recon;
    logic           chk_bad;

    always_comb begin
        recon   = ({{N{1'b0}}, shift_next} * {{2*N{1'b0}}, divisor_q})
                + {{2*N{1'b0}}, pr_next};
        chk_bad = (recon != {{N{1'b0}}, dividend_q}) || !(pr_next < divisor_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q <= '0;
            chk_err    <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                dividend_q <= dividend;
            end
            if (last_iter && chk_bad) begin
                chk_err <= 1'b1;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule
